// File: rtl/ser_shift_engine.sv
// Parallel-in/serial-out shift engine with valid/ready load, per-tick bit advance,
// selectable bit order, configurable idle level and synchronous flush.
// Optional parity bit after the data bits when SER_PARITY_EN is defined.
module ser_shift_engine #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          MSB_FIRST  = 1'b0,
  parameter logic        IDLE_VAL   = 1'b1,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] DATA,
  input  logic             Data_Valid,
  output logic             Ready,
  input  logic             Bit_Tick,
  input  logic             Flush,
  output logic             ser_out,
  output logic             ser_busy,
  output logic             ser_done
);

  localparam int unsigned   CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  // Terminal compare against WIDTH-1 keeps non-power-of-two widths exact.
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);
  localparam int unsigned   OutIdx  = MSB_FIRST ? WIDTH - 1 : 0;

`ifdef SER_PARITY_EN
  typedef enum logic [1:0] {StIdle, StData, StPar} state_e;
`else
  typedef enum logic [0:0] {StIdle, StData} state_e;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             out_q, out_d;

`ifdef SER_PARITY_EN
  logic par_q, par_d;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = PARITY_ODD;
`endif

  // Next-state, shift and output-level computation.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
`ifdef SER_PARITY_EN
    par_d   = par_q;
`endif
    if (Flush) begin
      // Abort wins over tick and load; no completion pulse.
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (Data_Valid) begin
            shreg_d = DATA;
            cnt_d   = '0;
            state_d = StData;
`ifdef SER_PARITY_EN
            par_d   = (^DATA) ^ PARITY_ODD;
`endif
          end
        end
        StData: begin
          if (Bit_Tick) begin
            if (cnt_q == CntLast) begin
`ifdef SER_PARITY_EN
              state_d = StPar;
`else
              state_d = StIdle;
              done_d  = 1'b1;
`endif
            end else begin
              shreg_d = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
              cnt_d   = cnt_q + CntW'(1);
            end
          end
        end
`ifdef SER_PARITY_EN
        StPar: begin
          if (Bit_Tick) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
`endif
        default: state_d = StIdle;
      endcase
    end

    // Line level is registered from the next state so it appears at the load edge.
    out_d = IDLE_VAL;
    unique case (state_d)
      StData:  out_d = shreg_d[OutIdx];
`ifdef SER_PARITY_EN
      StPar:   out_d = par_d;
`endif
      default: out_d = IDLE_VAL;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= StIdle;
      shreg_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      out_q   <= IDLE_VAL;
`ifdef SER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      out_q   <= out_d;
`ifdef SER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign Ready    = (state_q == StIdle);
  assign ser_busy = (state_q != StIdle);
  assign ser_done = done_q;
  assign ser_out  = out_q;

endmodule

// File: tb/tb_ser_shift_engine.sv
// Self-checking bench for ser_shift_engine: vector table for a 5-bit MSB-first
// instance, queue scoreboard for an 8-bit LSB-first instance.
module tb_ser_shift_engine;

`ifdef SER_PARITY_EN
  localparam int Frame8 = 9;
`else
  localparam int Frame8 = 8;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 8-bit LSB-first instance
  logic [7:0] dd;
  logic       dv, tk, fl;
  logic       o8, r8, b8, d8;

  ser_shift_engine #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_VAL(1'b1), .PARITY_ODD(1'b0)) u8 (
    .CLK(clk), .RST(rst_n), .DATA(dd), .Data_Valid(dv), .Ready(r8), .Bit_Tick(tk),
    .Flush(fl), .ser_out(o8), .ser_busy(b8), .ser_done(d8)
  );

  // 5-bit MSB-first instance
  logic [4:0] d5;
  logic       v5, t5, f5;
  logic       o5, r5, b5, dn5;

  ser_shift_engine #(.WIDTH(5), .MSB_FIRST(1'b1), .IDLE_VAL(1'b1), .PARITY_ODD(1'b0)) u5 (
    .CLK(clk), .RST(rst_n), .DATA(d5), .Data_Valid(v5), .Ready(r5), .Bit_Tick(t5),
    .Flush(f5), .ser_out(o5), .ser_busy(b5), .ser_done(dn5)
  );

`ifdef SER_PARITY_EN
  logic oo, ro, bo, dno;
  ser_shift_engine #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_VAL(1'b1), .PARITY_ODD(1'b1)) u8o (
    .CLK(clk), .RST(rst_n), .DATA(dd), .Data_Valid(dv), .Ready(ro), .Bit_Tick(tk),
    .Flush(fl), .ser_out(oo), .ser_busy(bo), .ser_done(dno)
  );
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard for the 8-bit instance
  bit   exp_q[$];
  logic m_busy = 1'b0;
  logic m_done = 1'b0;

  typedef struct {
    logic       v;
    logic [4:0] d;
    logic       t;
    logic       f;
    logic [3:0] exp;  // {ser_out, Ready, ser_busy, ser_done}
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: out/rdy/busy/done got %b want %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // One clock on the 8-bit instance: drive, clock, update scoreboard, compare.
  task automatic step8(input string name, input logic v, input logic [7:0] d,
                       input logic t, input logic f);
    logic eo;
    dv = v; dd = d; tk = t; fl = f;
    @(posedge clk);
    #1;
    m_done = 1'b0;
    if (f) begin
      exp_q.delete();
      m_busy = 1'b0;
    end else if (m_busy) begin
      if (t) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end
    end else if (v) begin
      for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
`ifdef SER_PARITY_EN
      exp_q.push_back(^d);
`endif
      m_busy = 1'b1;
    end
    eo = m_busy ? exp_q[0] : 1'b1;
    check(name, {o8, r8, b8, d8}, {eo, ~m_busy, m_busy, m_done});
  endtask

  initial begin
    int clk_cnt;
    int n_done;
    int t_done2;

    rst_n = 1'b0;
    dv = 1'b0; dd = '0; tk = 1'b0; fl = 1'b0;
    v5 = 1'b0; d5 = '0; t5 = 1'b0; f5 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset8", {o8, r8, b8, d8}, 4'b1100);
    check("reset5", {o5, r5, b5, dn5}, 4'b1100);
    rst_n = 1'b1;

    // MSB-first 5-bit table: 10011 -> 1,0,0,1,1 then done
    tbl.push_back('{v: 1'b0, d: 5'b00000, t: 1'b1, f: 1'b0, exp: 4'b1100});
    tbl.push_back('{v: 1'b1, d: 5'b10011, t: 1'b0, f: 1'b0, exp: 4'b1010});
    tbl.push_back('{v: 1'b0, d: 5'b10011, t: 1'b1, f: 1'b0, exp: 4'b0010});
    tbl.push_back('{v: 1'b0, d: 5'b10011, t: 1'b1, f: 1'b0, exp: 4'b0010});
    tbl.push_back('{v: 1'b0, d: 5'b10011, t: 1'b0, f: 1'b0, exp: 4'b0010});
    tbl.push_back('{v: 1'b0, d: 5'b10011, t: 1'b1, f: 1'b0, exp: 4'b1010});
    tbl.push_back('{v: 1'b0, d: 5'b10011, t: 1'b1, f: 1'b0, exp: 4'b1010});
`ifdef SER_PARITY_EN
    tbl.push_back('{v: 1'b0, d: 5'b10011, t: 1'b1, f: 1'b0, exp: 4'b1010});
`endif
    tbl.push_back('{v: 1'b0, d: 5'b10011, t: 1'b1, f: 1'b0, exp: 4'b1101});
    tbl.push_back('{v: 1'b0, d: 5'b10011, t: 1'b0, f: 1'b0, exp: 4'b1100});
    for (int i = 0; i < tbl.size(); i++) begin
      v5 = tbl[i].v; d5 = tbl[i].d; t5 = tbl[i].t; f5 = tbl[i].f;
      @(posedge clk);
      #1;
      check($sformatf("msb5_row%0d", i), {o5, r5, b5, dn5}, tbl[i].exp);
    end
    v5 = 1'b0; t5 = 1'b0;

    // Tick in idle is ignored, then reset mid-frame of A5
    step8("idle_tick", 1'b0, 8'h00, 1'b1, 1'b0);
    step8("a5_load", 1'b1, 8'hA5, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step8("a5_pre_rst", 1'b0, 8'hA5, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    m_busy = 1'b0;
    m_done = 1'b0;
    check("rst_async", {o8, r8, b8, d8}, 4'b1100);
    @(posedge clk);
    #1;
    check("rst_hold", {o8, r8, b8, d8}, 4'b1100);
    rst_n = 1'b1;
    step8("post_rst", 1'b0, 8'h00, 1'b1, 1'b0);

    // Full A5 frame, tick every cycle: 1,0,1,0,0,1,0,1
    step8("a5_load2", 1'b1, 8'hA5, 1'b0, 1'b0);
    for (int i = 0; i < Frame8; i++) step8("a5_bit", 1'b0, 8'h00, 1'b1, 1'b0);
    step8("a5_after", 1'b0, 8'h00, 1'b0, 1'b0);

    // Sparse ticks with 3C; FF offered mid-frame must be ignored
    step8("3c_load", 1'b1, 8'h3C, 1'b0, 1'b0);
    for (int i = 0; i < Frame8 * 4; i++)
      step8("3c_sparse", 1'b1, 8'hFF, (i % 4) == 3, 1'b0);
    step8("3c_after", 1'b0, 8'h00, 1'b0, 1'b0);

    // Back-to-back 01 then 80 with Data_Valid held high
    step8("b2b_load1", 1'b1, 8'h01, 1'b1, 1'b0);
    clk_cnt = 0;
    n_done  = 0;
    t_done2 = -1;
    for (int i = 0; i < 40 && t_done2 < 0; i++) begin
      step8("b2b_bit", 1'b1, 8'h80, 1'b1, 1'b0);
      clk_cnt++;
      if (d8) begin
        n_done++;
        if (n_done == 2) t_done2 = clk_cnt;
      end
    end
    check_int("b2b_clocks", t_done2, 2 * Frame8 + 1);
    step8("b2b_after", 1'b0, 8'h00, 1'b0, 1'b0);

    // Flush after 3rd bit of F0 with a competing load; next cycle's load accepted
    step8("f0_load", 1'b1, 8'hF0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step8("f0_bit", 1'b0, 8'h00, 1'b1, 1'b0);
    step8("flush", 1'b1, 8'h55, 1'b1, 1'b1);
    check("flush_idle", {o8, r8, b8, d8}, 4'b1100);
    step8("post_flush_load", 1'b1, 8'h55, 1'b0, 1'b0);
    for (int i = 0; i < Frame8; i++) step8("55_bit", 1'b0, 8'h00, 1'b1, 1'b0);
    step8("55_after", 1'b0, 8'h00, 1'b0, 1'b0);

`ifdef SER_PARITY_EN
    // Parity of 07: even sense 1, odd sense 0, on the 9th bit period
    step8("par_load", 1'b1, 8'h07, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step8("par_bit", 1'b0, 8'h00, 1'b1, 1'b0);
    check("par_even", {o8, r8, b8, d8}, 4'b1010);
    check("par_odd", {oo, ro, bo, dno}, 4'b0010);
    step8("par_tick9", 1'b0, 8'h00, 1'b1, 1'b0);
    check("par_odd_done", {oo, ro, bo, dno}, 4'b1101);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
